// File: rtl/ucode_pkg.sv
// Shared opcode, instruction-field and FSM-state definitions for the microcode sequencer.
package ucode_pkg;

  localparam int WORD_W  = 16;
  localparam int SEL_W   = 5;
  localparam int IMM_W   = 8;
  localparam int NUM_OPS = 8;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 13;
  localparam int SEL_HI = 12;
  localparam int SEL_LO = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_SETA = 3'd1,
    OP_WR   = 3'd2,
    OP_JMP  = 3'd3,
    OP_LDC  = 3'd4,
    OP_DJNZ = 3'd5,
    OP_HALT = 3'd6,
    OP_ILL  = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_e;

  function automatic opcode_e word_op(input logic [WORD_W-1:0] word);
    return opcode_e'(word[OP_HI:OP_LO]);
  endfunction

endpackage

// File: rtl/ucode_dec.sv
// Microinstruction decoder: splits a ROM word into one-hot opcode flags, sel and imm.
module ucode_dec
  import ucode_pkg::*;
(
  input  logic [WORD_W-1:0]  rom_data,
  output logic [NUM_OPS-1:0] op_oh,
  output logic [SEL_W-1:0]   sel,
  output logic [IMM_W-1:0]   imm
);

  // one flag per opcode; anything unrecognised decodes as illegal
  always_comb begin
    op_oh = {NUM_OPS{1'b0}};
    case (word_op(rom_data))
      OP_NOP:  op_oh[OP_NOP]  = 1'b1;
      OP_SETA: op_oh[OP_SETA] = 1'b1;
      OP_WR:   op_oh[OP_WR]   = 1'b1;
      OP_JMP:  op_oh[OP_JMP]  = 1'b1;
      OP_LDC:  op_oh[OP_LDC]  = 1'b1;
      OP_DJNZ: op_oh[OP_DJNZ] = 1'b1;
      OP_HALT: op_oh[OP_HALT] = 1'b1;
      default: op_oh[OP_ILL]  = 1'b1;
    endcase
  end

  assign sel = rom_data[SEL_HI:SEL_LO];
  assign imm = rom_data[IMM_HI:IMM_LO];

endmodule

// File: rtl/ucode_seq.sv
// Two-cycle-per-instruction microcode sequencer driving a register-file port.
// Define UCODE_SEQ_LOOP_EN to build the loop counter (LDC / DJNZ); otherwise both run as NOP.
module ucode_seq
  import ucode_pkg::*;
#(
  parameter int ROM_AW = 6,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              f_we,
  output logic [4:0]        fsel,
  output logic [7:0]        fin
);

  state_e              state_r;
  logic [ROM_AW-1:0]   pc_r;
  logic [ROM_AW-1:0]   rom_addr_r;
  logic                busy_r;
  logic                done_r;
  logic                err_r;
  logic                f_we_r;
  logic [SEL_W-1:0]    fsel_r;
  logic [IMM_W-1:0]    fin_r;

  logic [NUM_OPS-1:0]  op_oh_s;
  logic [SEL_W-1:0]    sel_s;
  logic [IMM_W-1:0]    imm_s;
  logic [ROM_AW-1:0]   pc_inc_s;
  logic [ROM_AW-1:0]   pc_next_s;
  logic                djnz_taken_s;
  logic                exec_go_s;
  logic                dec_unused_s;

  ucode_dec u_dec (
    .rom_data (rom_data),
    .op_oh    (op_oh_s),
    .sel      (sel_s),
    .imm      (imm_s)
  );

  assign exec_go_s = (state_r == ST_EXEC) && !abort;
  assign pc_inc_s  = pc_r + ROM_AW'(1);

`ifdef UCODE_SEQ_LOOP_EN
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_dec_s;

  // a zero counter decrements to all-ones, which is nonzero and therefore taken
  assign cnt_dec_s    = cnt_r - CNT_W'(1);
  assign djnz_taken_s = op_oh_s[OP_DJNZ] && (cnt_dec_s != {CNT_W{1'b0}});
  assign dec_unused_s = op_oh_s[OP_NOP];

  // loop counter, only touched by LDC and DJNZ in an un-aborted EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (exec_go_s && op_oh_s[OP_LDC]) begin
      cnt_r <= CNT_W'(imm_s);
    end else if (exec_go_s && op_oh_s[OP_DJNZ]) begin
      cnt_r <= cnt_dec_s;
    end
  end
`else
  assign djnz_taken_s = 1'b0;
  assign dec_unused_s = ^{op_oh_s[OP_NOP], op_oh_s[OP_LDC], op_oh_s[OP_DJNZ], imm_s, (CNT_W > 0)};
`endif

  // branch target selection; everything not taken falls through to pc+1
  always_comb begin
    pc_next_s = pc_inc_s;
    if (op_oh_s[OP_JMP] || djnz_taken_s) begin
      pc_next_s = imm_s[ROM_AW-1:0];
    end else begin
      pc_next_s = pc_inc_s;
    end
  end

  // main FSM with registered status and register-file outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      pc_r       <= {ROM_AW{1'b0}};
      rom_addr_r <= {ROM_AW{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      f_we_r     <= 1'b1;
      fsel_r     <= {SEL_W{1'b0}};
      fin_r      <= {IMM_W{1'b0}};
    end else begin
      done_r <= 1'b0;
      f_we_r <= 1'b1;
      if (abort) begin
        // abort beats any WR being decoded this cycle
        done_r  <= (state_r != ST_IDLE);
        state_r <= ST_IDLE;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start) begin
              pc_r       <= {ROM_AW{1'b0}};
              rom_addr_r <= {ROM_AW{1'b0}};
              err_r      <= 1'b0;
              busy_r     <= 1'b1;
              state_r    <= ST_FETCH;
            end
          end
          ST_FETCH: begin
            state_r <= ST_EXEC;
          end
          ST_EXEC: begin
            if (op_oh_s[OP_HALT] || op_oh_s[OP_ILL]) begin
              err_r   <= op_oh_s[OP_ILL];
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              if (op_oh_s[OP_SETA]) begin
                fsel_r <= sel_s;
              end
              if (op_oh_s[OP_WR]) begin
                f_we_r <= 1'b0;
                fin_r  <= imm_s;
              end
              pc_r       <= pc_next_s;
              rom_addr_r <= pc_next_s;
              state_r    <= ST_FETCH;
            end
          end
          default: begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;
  assign rom_addr = rom_addr_r;
  assign f_we     = f_we_r;
  assign fsel     = fsel_r;
  assign fin      = fin_r;

endmodule

// File: tb/tb_ucode_seq.sv
// Directed self-checking bench for ucode_seq with a synchronous behavioural ROM.
module tb_ucode_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        err;
  logic [5:0]  rom_addr;
  logic [15:0] rom_data;
  logic        f_we;
  logic [4:0]  fsel;
  logic [7:0]  fin;

  logic [15:0] rom [0:63];

  int n_chk;
  int n_err;
  int cyc_done;
  int n_wr;
  int n_done;
  int wr_fsel;
  int wr_fin;
  int wrap_seen;

  ucode_seq #(.ROM_AW(6), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .f_we     (f_we),
    .fsel     (fsel),
    .fin      (fin)
  );

  always #5 clk = ~clk;

  // ROM word appears one cycle after its address
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
  endtask

  // pulse start, then watch until one cycle past done; cyc 0 is the first cycle after the start edge
  task automatic go(input string tag, input int budget, input bit patch0);
    int cyc;
    int prev_addr;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    cyc_done = 0;
    n_wr = 0;
    n_done = 0;
    wrap_seen = 0;
    prev_addr = rom_addr;
    chk({tag, "_busy_start"}, busy, 1'b1);
    while (cyc <= budget) begin
      if (!f_we) begin
        n_wr++;
        wr_fsel = fsel;
        wr_fin = fin;
      end
      if (done) begin
        n_done++;
        if (cyc_done == 0) cyc_done = cyc;
      end
      if (prev_addr == 63 && rom_addr == 6'd0) wrap_seen = 1;
      prev_addr = rom_addr;
      if (patch0 && cyc == 2) rom[0] = 16'hC000;
      if (cyc_done != 0 && cyc > cyc_done) break;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_finished_in_budget"}, (cyc_done != 0), 1'b1);
  endtask

  initial begin
    int nw;
    int nd;
    clk = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    n_chk = 0;
    n_err = 0;
    rom_clear();

    #7;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_f_we", f_we, 1'b1);
    chk("rst_fsel", fsel, 5'd0);
    chk("rst_fin", fin, 8'd0);
    chk("rst_rom_addr", rom_addr, 6'd0);
    #5 rst_n = 1'b1;

    // SETA 5, WR 0xA5, HALT
    rom_clear();
    rom[0] = 16'h2500;
    rom[1] = 16'h40A5;
    rom[2] = 16'hC000;
    go("basic", 40, 1'b0);
    chk("basic_cycles", cyc_done, 6);
    chk("basic_writes", n_wr, 1);
    chk("basic_wr_fsel", wr_fsel, 5);
    chk("basic_wr_fin", wr_fin, 8'hA5);
    chk("basic_done_pulses", n_done, 1);
    chk("basic_err", err, 1'b0);
    chk("basic_f_we_idle", f_we, 1'b1);

    // LDC 3, SETA 1, WR 0x11, DJNZ 1, HALT
    rom_clear();
    rom[0] = 16'h8003;
    rom[1] = 16'h2100;
    rom[2] = 16'h4011;
    rom[3] = 16'hA001;
    rom[4] = 16'hC000;
    go("loop", 100, 1'b0);
`ifdef UCODE_SEQ_LOOP_EN
    chk("loop_writes", n_wr, 3);
    chk("loop_cycles", cyc_done, 22);
`else
    chk("loop_writes", n_wr, 1);
    chk("loop_cycles", cyc_done, 10);
`endif
    chk("loop_fsel", wr_fsel, 1);
    chk("loop_fin", wr_fin, 8'h11);
    chk("loop_done_pulses", n_done, 1);
    chk("loop_err", err, 1'b0);

    // LDC 0, WR 1, DJNZ 1, HALT: zero counter wraps and loops 255 more times
    rom_clear();
    rom[0] = 16'h8000;
    rom[1] = 16'h4001;
    rom[2] = 16'hA001;
    rom[3] = 16'hC000;
    go("djnz_wrap", 2000, 1'b0);
`ifdef UCODE_SEQ_LOOP_EN
    chk("djnz_wrap_writes", n_wr, 256);
    chk("djnz_wrap_cycles", cyc_done, 1028);
`else
    chk("djnz_wrap_writes", n_wr, 1);
    chk("djnz_wrap_cycles", cyc_done, 8);
`endif

    // abort while WR is in EXEC
    rom_clear();
    rom[0] = 16'h2700;
    rom[1] = 16'h405A;
    rom[2] = 16'hC000;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nw = 0;
    nd = 0;
    for (int c = 0; c < 6; c++) begin
      if (!f_we) nw++;
      if (done) nd++;
      if (c == 3) chk("abort_busy_in_exec", busy, 1'b1);
      if (c == 4) begin
        chk("abort_idle", busy, 1'b0);
        chk("abort_done", done, 1'b1);
        chk("abort_fsel", fsel, 5'd7);
      end
      abort = (c == 3);
      @(negedge clk);
    end
    abort = 1'b0;
    chk("abort_writes", nw, 0);
    chk("abort_done_pulses", nd, 1);

    // start together with abort is ignored
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    chk("start_abort_busy", busy, 1'b0);
    start = 1'b0;
    abort = 1'b0;

    // illegal word at pc 2
    rom_clear();
    rom[0] = 16'h2300;
    rom[2] = 16'hE000;
    rom[3] = 16'h40FF;
    go("illegal", 40, 1'b0);
    chk("illegal_cycles", cyc_done, 6);
    chk("illegal_err", err, 1'b1);
    chk("illegal_writes", n_wr, 0);
    chk("illegal_done_pulses", n_done, 1);
    repeat (3) @(negedge clk);
    chk("illegal_err_sticky", err, 1'b1);
    rom[2] = 16'hC000;
    go("restart", 40, 1'b0);
    chk("restart_err_cleared", err, 1'b0);
    chk("restart_cycles", cyc_done, 6);

    // 64 NOPs, address 0 becomes HALT once it has been fetched
    rom_clear();
    go("nop_wrap", 300, 1'b1);
    chk("nop_wrap_seen", wrap_seen, 1);
    chk("nop_wrap_writes", n_wr, 0);
    chk("nop_wrap_cycles", cyc_done, 130);

    // reset during a write pulse
    rom_clear();
    rom[0] = 16'h2900;
    rom[1] = 16'h4077;
    rom[2] = 16'hC000;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_pre_f_we", f_we, 1'b0);
    chk("rst_mid_pre_fin", fin, 8'h77);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_f_we", f_we, 1'b1);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_fsel", fsel, 5'd0);
    chk("rst_mid_fin", fin, 8'd0);
    chk("rst_mid_rom_addr", rom_addr, 6'd0);
    chk("rst_mid_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_after_f_we", f_we, 1'b1);
    chk("rst_mid_after_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ucode_seq.md
UCODE_SEQ -- requirements
Module: ucode_seq

Interface
REQ-001 SHALL have parameter ROM_AW, default 6, microprogram address width.
REQ-002 SHALL have parameter CNT_W, default 8, loop-counter width.
REQ-003 SHALL have port clk, input, 1, single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, run request, sampled in IDLE only.
REQ-006 SHALL have port abort, input, 1, synchronous stop, any state.
REQ-007 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-008 SHALL have port done, output, 1, one-cycle pulse on HALT, illegal opcode or abort.
REQ-009 SHALL have port err, output, 1, sticky illegal-opcode flag, cleared by the next accepted start.
REQ-010 SHALL have port rom_addr, output, ROM_AW, microprogram ROM address.
REQ-011 SHALL have port rom_data, input, 16, ROM word, valid one cycle after rom_addr.
REQ-012 SHALL have port f_we, output, 1, register-file control: 1 = load address from fsel, 0 = write fin.
REQ-013 SHALL have port fsel, output, 5, register-file address.
REQ-014 SHALL have port fin, output, 8, register-file write data.

Function
REQ-015 SHALL decode the word as op = rom_data[15:13], sel = [12:8], imm = [7:0].
- 000 NOP.
- 001 SETA: f_we=1, fsel=sel.
- 010 WR: f_we=0, fin=imm.
- 011 JMP: pc = imm[ROM_AW-1:0].
- 100 LDC: cnt = imm.
- 101 DJNZ: cnt = cnt-1; jump to imm if the result is nonzero.
- 110 HALT.
- 111 illegal.
REQ-016 SHALL implement the FSM IDLE -> FETCH -> EXEC -> FETCH..., with HALT or illegal in EXEC -> IDLE.
REQ-017 SHALL, on start in IDLE, set pc=0, enter FETCH and drive rom_addr=pc; EXEC consumes rom_data the next cycle, giving 2 cycles per instruction.
REQ-018 SHALL register f_we, fsel and fin, so they update on the edge ending EXEC.
REQ-019 SHALL drive f_we low for exactly one cycle per WR and high in every other cycle, because the register file writes whenever f_we=0.
REQ-020 SHALL hold fsel at the last SETA value and fin at the last WR value.
REQ-021 SHALL increment pc by one after every non-taken instruction, wrapping from 2^ROM_AW-1 to 0.
REQ-022 SHALL wrap cnt on DJNZ with cnt=0 to all-ones (nonzero, so taken).
REQ-023 SHALL, on illegal opcode, set err, pulse done and return to IDLE with no register-file write.
REQ-024 SHALL, on abort, return to IDLE on the next edge, pulse done, and force f_we=1 and fsel held; abort SHALL win over a WR in EXEC in the same cycle, so no write pulse.
REQ-025 SHALL ignore start while busy, and SHALL ignore start when abort is high in the same cycle.

Reset
REQ-026 SHALL, on rst_n low, asynchronously set state=IDLE, pc=0, cnt=0, rom_addr=0, busy=0, done=0, err=0, f_we=1, fsel=0 and fin=0.
REQ-027 SHALL, on reset asserted mid-program, suppress any pending write pulse, leaving f_we=1.

Configuration
REQ-028 SHALL, with UCODE_SEQ_LOOP_EN defined, implement the cnt register, LDC and DJNZ per REQ-015.
REQ-029 SHALL, without UCODE_SEQ_LOOP_EN, remove cnt and execute LDC and DJNZ as NOP (pc+1, no err).

Structure
REQ-030 SHALL place the opcode constants, field bit positions and FSM state encoding in a shared package ucode_pkg.
REQ-031 SHALL place the opcode decode in one sub-module ucode_dec (rom_data in, one-hot op flags plus sel and imm out); the FSM, pc and cnt SHALL stay in ucode_seq.

Verification
REQ-032 SHALL cover: ROM [SETA 5, WR 0xA5, HALT], start -> f_we low exactly one cycle with fsel=5 and fin=0xA5; done pulses in the cycle the FSM enters IDLE; total 6 cycles from start.
REQ-033 SHALL cover, with UCODE_SEQ_LOOP_EN: LDC 3, SETA 1, WR 0x11, DJNZ to 1, HALT -> exactly 3 write pulses, then done.
REQ-034 SHALL cover: abort asserted in the cycle EXEC decodes WR -> no f_we low pulse, done pulses once, IDLE next cycle.
REQ-035 SHALL cover: word 0xE000 at pc 2 -> err=1 and done pulses; err stays 1 until the next start, which clears it.
REQ-036 SHALL cover: 64 consecutive NOP words with HALT at address 0 reached again -> rom_addr wraps 63 -> 0 with no write.
REQ-037 SHALL cover: rst_n pulsed low mid-WR -> all outputs at reset values immediately and asynchronously, f_we=1.
